seg_scan_driver: RTL and testbench

Time-multiplexed seven-segment scan driver sitting directly downstream of the timer's BCD/segment display stage. It takes the packed per-digit segment patterns (e.g. the timer's 14-bit `cur_time`, two 7-segment codes), latches them once per frame, and drives a shared segment bus plus one-hot digit enables at a fixed refresh rate. An optional blanking window at each digit switch suppresses ghosting on the board's common-anode displays.

---
 rtl/seg_scan_driver_pkg.sv | 16 +
 rtl/seg_scan_driver_if.sv | 19 +
 rtl/scan_prescaler.sv | 28 ++
 rtl/seg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver package: scan FSM state encoding and the inactive-level
// helper used to build the "all segments off" / "all digits off" patterns.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // Level that turns a line off: an active-low line is off when high.
   function automatic logic off_level(input int active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver bus: frame data in, multiplexed display lines out.
interface seg_scan_driver_if #(
   parameter int DIGIT_CNT = 2,
   parameter int SEG_W     = 7
);
   // Signal semantics: there is no valid/ready pair here. en is a level
   // (high = keep scanning, low = blank and park the scanner); seg_in is
   // sampled only on the cycle a frame loads, so the source may change it at
   // any time; seg_out/dig_sel are registered levels and frame_start is a
   // one-cycle pulse marking the first cycle of each frame.
   logic                       en;
   logic [DIGIT_CNT*SEG_W-1:0] seg_in;
   logic [SEG_W-1:0]           seg_out;
   logic [DIGIT_CNT-1:0]       dig_sel;
   logic                       frame_start;

   modport master (output en, seg_in, input seg_out, dig_sel, frame_start);
   modport slave  (input en, seg_in, output seg_out, dig_sel, frame_start);
endinterface

// File: rtl/scan_prescaler.sv
// scan_prescaler: counts clk cycles within one digit slot (0..SCAN_DIV-1),
// with synchronous clear and a terminal-count strobe on the last cycle.
module scan_prescaler #(
   parameter int SCAN_DIV = 50_000,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   assign tc = en && (cnt == CNT_W'(SCAN_DIV - 1));

   // Slot counter: clear wins, otherwise count and wrap on terminal count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scan driver. Latches the
// packed digit patterns once per frame and walks the digits one slot at a
// time on a shared segment bus. Optional feature macro SEG_SCAN_BLANK_EN:
// when defined, each slot starts with a BLANK_CYC all-off window to suppress
// ghosting; when undefined, digits hand over directly in one edge.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int DIGIT_CNT      = 2,
   parameter int SEG_W          = 7,
   parameter int SCAN_DIV       = 50_000,
   parameter int BLANK_CYC      = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rstn,
   seg_scan_driver_if.slave   bus,
   output scan_state_t        state_dbg
);

   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SLOT_W = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;

`ifdef SEG_SCAN_BLANK_EN
   localparam int BLANK_LEN = BLANK_CYC;
`else
   // Blanking compiled out: the window length collapses to zero.
   localparam int BLANK_LEN = BLANK_CYC * 0;
`endif
   localparam bit BLANK_ON = (BLANK_LEN != 0);

   localparam logic [SEG_W-1:0]     SEG_OFF = {SEG_W{off_level(SEG_ACTIVE_LOW)}};
   localparam logic [DIGIT_CNT-1:0] DIG_OFF = {DIGIT_CNT{off_level(DIG_ACTIVE_LOW)}};

   scan_state_t                state;
   logic [SLOT_W-1:0]          slot;
   logic [DIGIT_CNT*SEG_W-1:0] shadow;
   logic [CNT_W-1:0]           cnt;
   logic                       tc;
   logic                       slot_last;
   logic [SLOT_W-1:0]          slot_next;

   // Segment pattern of digit s taken from a packed frame, bus polarity applied.
   function automatic logic [SEG_W-1:0] seg_drive(
      input logic [DIGIT_CNT*SEG_W-1:0] pat,
      input logic [SLOT_W-1:0]          s
   );
      logic [SEG_W-1:0] d;
      d = pat[int'(s)*SEG_W +: SEG_W];
      return (SEG_ACTIVE_LOW != 0) ? ~d : d;
   endfunction

   // One-hot enable for digit s, bus polarity applied.
   function automatic logic [DIGIT_CNT-1:0] dig_drive(input logic [SLOT_W-1:0] s);
      logic [DIGIT_CNT-1:0] oh;
      for (int k = 0; k < DIGIT_CNT; k++) begin
         oh[k] = (s == SLOT_W'(k));
      end
      return (DIG_ACTIVE_LOW != 0) ? ~oh : oh;
   endfunction

   // The counter only runs while a frame is being scanned; parking in IDLE
   // (or dropping en) holds it at zero so every frame starts cleanly.
   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk  (clk),
      .rstn (rstn),
      .clr  ((state == ST_IDLE) || !bus.en),
      .en   (state != ST_IDLE),
      .cnt  (cnt),
      .tc   (tc)
   );

   assign slot_last = (slot == SLOT_W'(DIGIT_CNT - 1));
   assign slot_next = slot_last ? '0 : slot + SLOT_W'(1);
   assign state_dbg = state;

`ifdef SEG_SCAN_BLANK_EN
   logic blank_done;
   assign blank_done = (cnt == CNT_W'(BLANK_LEN - 1));
`endif

   // Scan FSM; outputs are computed from the next state/slot/shadow so they
   // line up with the state register and never show two digits at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         slot        <= '0;
         shadow      <= '0;
         bus.seg_out <= SEG_OFF;
         bus.dig_sel <= DIG_OFF;
         bus.frame_start <= 1'b0;
      end else if (!bus.en) begin
         state       <= ST_IDLE;
         slot        <= '0;
         bus.seg_out <= SEG_OFF;
         bus.dig_sel <= DIG_OFF;
         bus.frame_start <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               slot            <= '0;
               shadow          <= bus.seg_in;
               bus.frame_start <= 1'b1;
               if (BLANK_ON) begin
                  state       <= ST_BLANK;
                  bus.seg_out <= SEG_OFF;
                  bus.dig_sel <= DIG_OFF;
               end else begin
                  state       <= ST_DRIVE;
                  bus.seg_out <= seg_drive(bus.seg_in, '0);
                  bus.dig_sel <= dig_drive('0);
               end
            end
`ifdef SEG_SCAN_BLANK_EN
            ST_BLANK: begin
               bus.frame_start <= 1'b0;
               if (blank_done) begin
                  state       <= ST_DRIVE;
                  bus.seg_out <= seg_drive(shadow, slot);
                  bus.dig_sel <= dig_drive(slot);
               end else begin
                  bus.seg_out <= SEG_OFF;
                  bus.dig_sel <= DIG_OFF;
               end
            end
`endif
            ST_DRIVE: begin
               if (tc) begin
                  slot <= slot_next;
                  if (slot_last) begin
                     shadow          <= bus.seg_in;
                     bus.frame_start <= 1'b1;
                  end else begin
                     bus.frame_start <= 1'b0;
                  end
                  if (BLANK_ON) begin
                     state       <= ST_BLANK;
                     bus.seg_out <= SEG_OFF;
                     bus.dig_sel <= DIG_OFF;
                  end else begin
                     state       <= ST_DRIVE;
                     bus.seg_out <= seg_drive(slot_last ? bus.seg_in : shadow, slot_next);
                     bus.dig_sel <= dig_drive(slot_next);
                  end
               end else begin
                  bus.frame_start <= 1'b0;
                  bus.seg_out     <= seg_drive(shadow, slot);
                  bus.dig_sel     <= dig_drive(slot);
               end
            end
            default: begin
               state       <= ST_IDLE;
               slot        <= '0;
               bus.seg_out <= SEG_OFF;
               bus.dig_sel <= DIG_OFF;
               bus.frame_start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGIT_CNT=2, SCAN_DIV=8, BLANK_CYC=2, both
// polarities active-low). Follows SEG_SCAN_BLANK_EN the same way the design
// does, so it fits either build.
module tb_seg_scan_driver;
   import seg_scan_pkg::*;

   localparam int DIGIT_CNT = 2;
   localparam int SEG_W     = 7;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = DIGIT_CNT * SCAN_DIV;
`ifdef SEG_SCAN_BLANK_EN
   localparam int BLANK_EFF = BLANK_CYC;
`else
   localparam int BLANK_EFF = 0;
`endif

   logic        clk;
   logic        rstn;
   scan_state_t state_dbg;
   int          vectors;
   int          miscompares;
   bit          cmp_on;

   seg_scan_driver_if #(.DIGIT_CNT(DIGIT_CNT), .SEG_W(SEG_W)) sif ();

   seg_scan_driver #(
      .DIGIT_CNT      (DIGIT_CNT),
      .SEG_W          (SEG_W),
      .SCAN_DIV       (SCAN_DIV),
      .BLANK_CYC      (BLANK_CYC),
      .SEG_ACTIVE_LOW (1),
      .DIG_ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (sif),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the frame and the frame's latched data.
   bit                         m_act;
   int                         m_t;
   logic [DIGIT_CNT*SEG_W-1:0] m_shadow;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_act    <= 1'b0;
         m_t      <= 0;
         m_shadow <= '0;
      end else if (!sif.en) begin
         m_act <= 1'b0;
      end else if (!m_act) begin
         m_act    <= 1'b1;
         m_t      <= 0;
         m_shadow <= sif.seg_in;
      end else if (m_t == FRAME - 1) begin
         m_t      <= 0;
         m_shadow <= sif.seg_in;
      end else begin
         m_t <= m_t + 1;
      end
   end

   // Per-cycle compare of all outputs against the model.
   always @(negedge clk) begin
      int                   sl;
      bit                   on;
      logic [DIGIT_CNT-1:0] oh;
      logic [SEG_W-1:0]     e_seg;
      logic [DIGIT_CNT-1:0] e_sel;
      if (cmp_on) begin
         sl = m_t / SCAN_DIV;
         on = m_act && ((m_t % SCAN_DIV) >= BLANK_EFF);
         oh = '0;
         oh[sl] = 1'b1;
         e_sel = on ? ~oh : '1;
         e_seg = on ? ~m_shadow[sl*SEG_W +: SEG_W] : '1;
         chk("model_seg_out", 32'(sif.seg_out), 32'(e_seg));
         chk("model_dig_sel", 32'(sif.dig_sel), 32'(e_sel));
         chk("model_frame_start", 32'(sif.frame_start), 32'(m_act && (m_t == 0)));
      end
   end

   task automatic chk_inactive(input string name);
      chk({name, "_seg"}, 32'(sif.seg_out), 32'h7F);
      chk({name, "_dig"}, 32'(sif.dig_sel), 32'h3);
      chk({name, "_fs"},  32'(sif.frame_start), 32'h0);
   endtask

   // Stimulus driver with hand-computed pins.
   initial begin
      vectors     = 0;
      miscompares = 0;
      cmp_on      = 1'b0;
      rstn        = 1'b0;
      sif.en      = 1'b0;
      sif.seg_in  = '0;

      #12;
      chk_inactive("reset");
      cmp_on = 1'b1;
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(negedge clk);

      // scan: digit1=06, digit0=3F
      sif.seg_in = {7'h06, 7'h3F};
      sif.en     = 1'b1;
      @(posedge clk); #1;
      chk("scan_c0_fs", 32'(sif.frame_start), 32'h1);
`ifdef SEG_SCAN_BLANK_EN
      chk("scan_c0_blank_dig", 32'(sif.dig_sel), 32'h3);
`else
      chk("scan_c0_dig", 32'(sif.dig_sel), 32'h2);
`endif
      repeat (3) @(posedge clk); #1;
      chk("scan_c3_seg", 32'(sif.seg_out), 32'h40);
      chk("scan_c3_dig", 32'(sif.dig_sel), 32'h2);
      repeat (9) @(posedge clk); #1;
      chk("scan_c12_seg", 32'(sif.seg_out), 32'h79);
      chk("scan_c12_dig", 32'(sif.dig_sel), 32'h1);
      repeat (4) @(posedge clk); #1;
      chk("scan_c16_fs", 32'(sif.frame_start), 32'h1);

      // tearing: new data during digit 0 drive shows only next frame
      repeat (3) @(posedge clk); #1;
      @(negedge clk) sif.seg_in = {7'h5B, 7'h4F};
      repeat (9) @(posedge clk); #1;
      chk("tear_old_seg", 32'(sif.seg_out), 32'h79);
      repeat (4) @(posedge clk); #1;
      chk("tear_fs", 32'(sif.frame_start), 32'h1);
      repeat (3) @(posedge clk); #1;
      chk("tear_new_d0", 32'(sif.seg_out), 32'h30);
      repeat (9) @(posedge clk); #1;
      chk("tear_new_d1", 32'(sif.seg_out), 32'h24);

      // enable drop mid-drive
      @(negedge clk) sif.en = 1'b0;
      @(posedge clk); #1;
      chk_inactive("en_drop");
      repeat (2) @(negedge clk);
      sif.en = 1'b1;
      @(posedge clk); #1;
      chk("en_return_fs", 32'(sif.frame_start), 32'h1);

      // randomized en / data
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         sif.en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 7) == 0) sif.seg_in = 14'($urandom);
      end

      // async reset between edges
      @(negedge clk) sif.en = 1'b1;
      repeat (20) @(posedge clk);
      #2 rstn = 1'b0;
      #1 chk_inactive("async_rst");
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      chk("async_rst_restart_fs", 32'(sif.frame_start), 32'h1);
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
